// File: rtl/life_pkg.sv
// life_pkg: shared FSM state type and sizing constants for the life array scan-out.
package life_pkg;
    typedef enum logic [2:0] {IDLE, STEP, SETTLE, CAPTURE, SHIFT} state_t;
    localparam int N_CELLS_DEFAULT = 16;
    localparam int GEN_W = 16;
endpackage

// File: rtl/life_piso.sv
// life_piso: parallel-in serial-out snapshot register with a ready handshake, LSB first.
module life_piso
    import life_pkg::*;
#(
    parameter int N = N_CELLS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         active,
    input  logic         ready,
    input  logic [N-1:0] din,
    output logic         sdata,
    output logic         sfirst,
    output logic         slast,
    output logic         last_acc
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    logic [N-1:0]  sh;
    logic [IW-1:0] idx;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            sh  <= din;
            idx <= '0;
        end else if (active && ready && !slast)
            idx <= idx + 1'b1;
    assign sdata    = active & sh[idx];
    assign sfirst   = active & (idx == '0);
    assign slast    = active & (idx == IW'(N - 1));
    assign last_acc = slast & ready;
endmodule

// File: rtl/life_scan_out.sv
// life_scan_out: steps the life array on request and streams a snapshot of its cells out serially.
module life_scan_out
    import life_pkg::*;
#(
    parameter int N_CELLS    = N_CELLS_DEFAULT,
    parameter int SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CELLS-1:0] alive,
    input  logic               step_req,
    input  logic               scan_req,
    output logic               run,
    output logic               busy,
    output logic               sdata,
    output logic               svalid,
    input  logic               out_ready,
    output logic               sfirst,
    output logic               slast,
    output logic               done,
    output logic [GEN_W-1:0]   gen_count
);
    localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    state_t        state, nxt;
    logic [SW-1:0] cnt;
    logic          last_acc;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = step_req ? STEP : scan_req ? CAPTURE : IDLE;
            STEP:    nxt = SETTLE_CYC == 0 ? CAPTURE : SETTLE;
            SETTLE:  nxt = cnt == '0 ? CAPTURE : SETTLE;
            CAPTURE: nxt = SHIFT;
            SHIFT:   nxt = last_acc ? IDLE : SHIFT;
            default: nxt = IDLE;
        endcase
    end
    // settle counter is loaded while stepping so SETTLE sees the full count on entry
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt       <= '0;
            gen_count <= '0;
            done      <= 1'b0;
        end else begin
            if (state == STEP)
                cnt <= SW'(SETTLE_CYC - 1);
            else if (state == SETTLE && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == STEP)
                gen_count <= gen_count + 1'b1;
            done <= (state == SHIFT) && last_acc;
        end
    assign run    = state == STEP;
    assign busy   = state != IDLE;
    assign svalid = state == SHIFT;
    life_piso #(.N(N_CELLS)) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (state == CAPTURE),
        .active   (svalid),
        .ready    (out_ready),
        .din      (alive),
        .sdata    (sdata),
        .sfirst   (sfirst),
        .slast    (slast),
        .last_acc (last_acc)
    );
endmodule

// File: tb/tb_life_scan_out.sv
// tb_life_scan_out: scoreboard bench; stimulus queues expected frame bits, a monitor checks accepted bits and done.
module tb_life_scan_out;
    logic        clk = 0, reset = 1, step_req = 0, scan_req = 0, out_ready = 1;
    logic [15:0] alive = '0;
    logic        run, busy, sdata, svalid, sfirst, slast, done;
    logic [15:0] gen_count;

    life_scan_out dut (
        .clk(clk), .reset(reset), .alive(alive), .step_req(step_req), .scan_req(scan_req),
        .run(run), .busy(busy), .sdata(sdata), .svalid(svalid), .out_ready(out_ready),
        .sfirst(sfirst), .slast(slast), .done(done), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic d; logic f; logic l;} exp_t;
    exp_t q[$];
    exp_t e;
    int pass_n = 0, total_n = 0, nacc = 0, done_cnt = 0, run_cnt = 0, base;
    logic done_pend = 0;
    logic [15:0] g0;
    int r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (run) run_cnt++;
        if (done_pend) begin
            chk("done_pulse", done, 1);
            if (done) done_cnt++;
            done_pend = 0;
        end else if (done) chk("unexpected_done", done, 0);
        if (svalid && out_ready) begin
            if (q.size() == 0) begin
                total_n++;
                $display("FAIL unexpected_bit: got sdata=%0b with nothing expected", sdata);
            end else begin
                e = q.pop_front();
                chk("sdata", sdata, e.d);
                chk("sfirst", sfirst, e.f);
                chk("slast", slast, e.l);
                nacc++;
                if (e.l) done_pend = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] v);
        for (int i = 0; i < 16; i++) q.push_back(exp_t'{v[i], i == 0, i == 15});
    endtask

    task automatic pulse(input logic st, input logic sc);
        step_req = st;
        scan_req = sc;
        tick();
        step_req = 0;
        scan_req = 0;
    endtask

    task automatic wait_frame(input string name);
        int d0 = done_cnt;
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            ok = (done_cnt > d0) && (q.size() == 0);
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 200 && nacc < n; i++) tick();
        chk("reach_bit", nacc, n);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_outs", {run, busy, svalid, sdata, sfirst, slast, done}, 0);
        chk("reset_gen", gen_count, 0);
        reset = 0;
        tick();

        alive = 16'hA5C3;
        push_frame(16'hA5C3);
        pulse(0, 1);
        wait_frame("scan_frame");
        chk("scan_run_never", run_cnt, 0);
        chk("scan_gen", gen_count, 0);
        chk("scan_idle", busy, 0);

        alive = 16'h1111;
        push_frame(16'h3C5A);
        pulse(1, 0);
        chk("step_run", run, 1);
        tick();
        chk("step_run_once", run, 0);
        chk("step_gen", gen_count, 1);
        tick();
        chk("capture_no_svalid", svalid, 0);
        alive = 16'h3C5A;
        tick();
        chk("step_svalid", svalid, 1);
        alive = 16'hFFFF;
        wait_frame("step_frame");
        chk("step_run_cnt", run_cnt, 1);

        base = nacc;
        alive = 16'h5AF0;
        push_frame(16'h5AF0);
        pulse(0, 1);
        wait_acc(base + 7);
        out_ready = 0;
        repeat (5) begin
            chk("bp_sdata", sdata, 1);
            chk("bp_slast", slast, 0);
            chk("bp_sfirst", sfirst, 0);
            chk("bp_svalid", svalid, 1);
            tick();
        end
        chk("bp_hold", nacc, base + 7);
        out_ready = 1;
        wait_frame("bp_frame");
        chk("bp_count", nacc - base, 16);

        g0 = gen_count;
        r0 = run_cnt;
        base = nacc;
        alive = 16'h0F0F;
        push_frame(16'h0F0F);
        pulse(1, 1);
        chk("sim_run", run, 1);
        wait_acc(base + 3);
        pulse(1, 0);
        pulse(1, 1);
        wait_frame("sim_frame");
        chk("sim_gen", gen_count, 16'(g0 + 1));
        chk("sim_runs", run_cnt, r0 + 1);
        tick();
        tick();
        chk("no_requeue", busy, 0);

        force dut.gen_count = 16'hFFFF;
        tick();
        release dut.gen_count;
        tick();
        chk("preload", gen_count, 16'hFFFF);
        push_frame(16'h0F0F);
        pulse(1, 0);
        wait_frame("wrap_frame");
        chk("wrap_gen", gen_count, 0);

        base = nacc;
        alive = 16'hBEEF;
        push_frame(16'hBEEF);
        pulse(0, 1);
        wait_acc(base + 9);
        reset = 1;
        #1;
        chk("rst_outs", {run, busy, svalid, sdata, sfirst, slast, done}, 0);
        chk("rst_gen", gen_count, 0);
        q.delete();
        tick();
        tick();
        reset = 0;
        tick();
        tick();
        alive = 16'h0001;
        push_frame(16'h0001);
        pulse(0, 1);
        tick();
        chk("post_rst_sfirst", sfirst, 1);
        chk("post_rst_sdata", sdata, 1);
        wait_frame("post_rst_frame");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
